// File: rtl/mem_port_sched_if.sv
// Scheduler-side bundle: fetch port, data port, memory port and stack pointer.
interface mem_port_sched_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic              d_push;
  logic              d_pop;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic              d_err;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [ADDR_W-1:0] sp;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_push, d_pop, d_addr, d_wdata,
           mem_rdata, mem_ready,
    output if_valid, if_rdata, d_done, d_err, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, sp
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_push, d_pop, d_addr, d_wdata,
           mem_rdata, mem_ready,
    input  if_valid, if_rdata, d_done, d_err, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, sp
  );
endinterface

// File: rtl/mem_port_sched.sv
// Single-port memory scheduler: data-over-fetch arbitration with a fetch
// starvation guard, plus a downward-growing stack whose pointer lives here.
module mem_port_sched #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16,
  parameter int STACK_TOP   = 1023,
  parameter int STACK_DEPTH = 64,
  parameter int STARVE_MAX  = 3
) (
  input logic             clk,
  input logic             rst,
  mem_port_sched_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] SP_EMPTY = ADDR_W'(STACK_TOP);
  localparam logic [ADDR_W-1:0] SP_FULL  = ADDR_W'(STACK_TOP - STACK_DEPTH);
  localparam logic [SW-1:0]     ST_MAX   = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic [2:0] {OP_FETCH, OP_LOAD, OP_STORE, OP_PUSH, OP_POP, OP_ILL} op_e;

  state_e state_q, state_d;
  op_e    op_q, op_d, dop;
  logic   grant_f, derr;

  logic [ADDR_W-1:0] sp_q, sp_d, mem_addr_q, mem_addr_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_valid_q, if_valid_d, d_done_q, d_done_d, d_err_q, d_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;

  // Arbitration and op decode, evaluated only while IDLE.
  always_comb begin
    grant_f = bus.if_req && (!bus.d_req || starve_q == ST_MAX);
    dop     = OP_LOAD;
    if (bus.d_push && bus.d_pop) dop = OP_ILL;
    else if (bus.d_push)         dop = OP_PUSH;
    else if (bus.d_pop)          dop = OP_POP;
    else if (bus.d_we)           dop = OP_STORE;
    derr = (dop == OP_ILL) || (dop == OP_PUSH && sp_q == SP_FULL) ||
           (dop == OP_POP && sp_q == SP_EMPTY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_f) state_d = ACCESS;
               else if (bus.d_req) state_d = derr ? RESP : ACCESS;
      ACCESS:  if (bus.mem_ready) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d        = op_q;
    sp_d        = sp_q;
    starve_d    = starve_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    d_done_d    = 1'b0;
    d_err_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_f) begin
          starve_d   = '0;
          op_d       = OP_FETCH;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr;
        end else if (bus.d_req) begin
          if (bus.if_req && starve_q != ST_MAX) starve_d = starve_q + SW'(1);
          if (derr) begin
            d_done_d = 1'b1;
            d_err_d  = 1'b1;
          end else begin
            op_d        = dop;
            mem_en_d    = 1'b1;
            mem_wdata_d = bus.d_wdata;
            case (dop)
              OP_PUSH:  begin mem_we_d = 1'b1; mem_addr_d = sp_q; end
              OP_POP:   begin mem_we_d = 1'b0; mem_addr_d = sp_q + ADDR_W'(1); end
              OP_STORE: begin mem_we_d = 1'b1; mem_addr_d = bus.d_addr; end
              default:  begin mem_we_d = 1'b0; mem_addr_d = bus.d_addr; end
            endcase
          end
        end
      end
      ACCESS: begin
        if (bus.mem_ready) begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          case (op_q)
            OP_FETCH: begin if_valid_d = 1'b1; if_rdata_d = bus.mem_rdata; end
            OP_LOAD:  begin d_done_d = 1'b1; d_rdata_d = bus.mem_rdata; end
            OP_POP:   begin d_done_d = 1'b1; d_rdata_d = bus.mem_rdata; sp_d = sp_q + ADDR_W'(1); end
            OP_PUSH:  begin d_done_d = 1'b1; sp_d = sp_q - ADDR_W'(1); end
            default:  d_done_d = 1'b1;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q        <= OP_FETCH;
      sp_q        <= SP_EMPTY;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_done_q    <= 1'b0;
      d_err_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      op_q        <= op_d;
      sp_q        <= sp_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      d_done_q    <= d_done_d;
      d_err_q     <= d_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.sp        = sp_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_done    = d_done_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;
endmodule
